// File: rtl/bitreverse_in_pkg.sv
// Shared types for the input-side bit-reversal reorder buffer.
package bitreverse_in_pkg;

   // Frame-alignment state of the write side.
   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      FILL      = 2'd1,
      RUN       = 2'd2
   } state_e;

endpackage : bitreverse_in_pkg

// File: rtl/brev_dpram.sv
// Simple dual-port RAM: one write port and one i_ce-gated registered read port.
module brev_dpram #(
   parameter int unsigned AW = 6,
   parameter int unsigned DW = 48
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_ce,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [0:DEPTH-1];
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] rdata_d;

   // Write port; contents are never reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   // Read data advances only on a sample strobe, otherwise holds.
   always_comb begin
      rdata_d = rdata_q;
      if (i_ce) begin
         rdata_d = mem[i_raddr];
      end
   end

   // Output register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign o_rdata = rdata_q;

endmodule : brev_dpram

// File: rtl/bitreverse_in.sv
// Natural-order to bit-reversed-order frame reorder with sync alignment.
module bitreverse_in
   import bitreverse_in_pkg::*;
#(
   parameter int unsigned LGSIZE = 5,
   parameter int unsigned WIDTH  = 24
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_ce,
   input  logic                 i_sync,
   input  logic [2*WIDTH-1:0]   i_in,
   output logic [2*WIDTH-1:0]   o_out,
   output logic                 o_sync,
   output logic                 o_err
);

   localparam int unsigned SW = 2 * WIDTH;
   localparam int unsigned AW = LGSIZE + 1;
   localparam logic [LGSIZE-1:0] CNT_LAST = '1;

   state_e            state_q, state_d;
   logic [LGSIZE-1:0] cnt_q, cnt_d;
   logic              bank_q, bank_d;
   logic              sync_q, sync_d;
   logic              err_q, err_d;

   logic              we_c;
   logic              restart_c;
   logic [LGSIZE-1:0] brev_cnt_c;
   logic [AW-1:0]     wr_addr_c;
   logic [AW-1:0]     rd_addr_c;

   // Bit-reversed frame counter used as the write index.
   for (genvar gi = 0; gi < LGSIZE; gi++) begin : g_brev
      assign brev_cnt_c[gi] = cnt_q[LGSIZE-1-gi];
   end

   // A (re)started frame always lands at slot 0 of the current bank.
   assign wr_addr_c = restart_c ? {bank_q, LGSIZE'(0)} : {bank_q, brev_cnt_c};
   assign rd_addr_c = {~bank_q, cnt_q};

   // Next-state: alignment, fill/run sequencing, misplaced-sync recovery.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bank_d    = bank_q;
      sync_d    = sync_q;
      err_d     = 1'b0;
      we_c      = 1'b0;
      restart_c = 1'b0;
      if (i_ce) begin
         sync_d = 1'b0;
         case (state_q)
            WAIT_SYNC: begin
               if (i_sync) begin
                  we_c      = 1'b1;
                  restart_c = 1'b1;
                  cnt_d     = LGSIZE'(1);
                  state_d   = FILL;
               end
            end
            FILL, RUN: begin
               we_c = 1'b1;
               if (i_sync && (cnt_q != '0)) begin
                  restart_c = 1'b1;
                  cnt_d     = LGSIZE'(1);
                  state_d   = FILL;
                  err_d     = 1'b1;
               end else begin
                  cnt_d = cnt_q + LGSIZE'(1);
                  if (state_q == RUN) begin
                     sync_d = (cnt_q == '0);
                  end
                  if (cnt_q == CNT_LAST) begin
                     bank_d  = ~bank_q;
                     state_d = RUN;
                  end
               end
            end
            default: begin
               state_d = WAIT_SYNC;
            end
         endcase
      end
   end

   // State and control registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= WAIT_SYNC;
         cnt_q   <= '0;
         bank_q  <= 1'b0;
         sync_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         sync_q  <= sync_d;
         err_q   <= err_d;
      end
   end

   brev_dpram #(
      .AW (AW),
      .DW (SW)
   ) u_ram (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_ce    (i_ce),
      .i_we    (we_c),
      .i_waddr (wr_addr_c),
      .i_wdata (i_in),
      .i_raddr (rd_addr_c),
      .o_rdata (o_out)
   );

   assign o_sync = sync_q;
   assign o_err  = err_q;

endmodule : bitreverse_in

// File: tb/tb_bitreverse_in.sv
// Directed self-checking bench for bitreverse_in (N=8, 8-bit components).
module tb_bitreverse_in;

   logic        i_clk;
   logic        i_reset;
   logic        i_ce;
   logic        i_sync;
   logic [15:0] i_in;
   logic [15:0] o_out;
   logic        o_sync;
   logic        o_err;

   int n_pass;
   int n_total;
   int e1 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
   int e3 [8] = '{3, 7, 5, 9, 4, 8, 6, 10};

   bitreverse_in #(.LGSIZE(3), .WIDTH(8)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_ce    (i_ce),
      .i_sync  (i_sync),
      .i_in    (i_in),
      .o_out   (o_out),
      .o_sync  (o_sync),
      .o_err   (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [15:0] mk(input int k);
      return {8'(k), 8'(k ^ 165)};
   endfunction

   function automatic int brev3(input int j);
      logic [2:0] b;
      b = 3'(j);
      return int'({b[0], b[1], b[2]});
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic s, input int k);
      i_ce   = 1'b1;
      i_sync = s;
      i_in   = mk(k);
      @(posedge i_clk);
      #1;
      i_ce   = 1'b0;
      i_sync = 1'b0;
   endtask

   task automatic idle();
      i_ce   = 1'b0;
      i_sync = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      i_ce    = 1'b0;
      i_sync  = 1'b0;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      i_reset = 1'b0;
      i_ce    = 1'b0;
      i_sync  = 1'b0;
      i_in    = '0;
      #1;

      // Reset values.
      do_reset();
      do_reset();
      check("rst_out", o_out, 16'h0);
      check("rst_sync", {15'b0, o_sync}, 16'h0);
      check("rst_err", {15'b0, o_err}, 16'h0);

      // Aligned stream, i_ce every clock.
      for (int k = 0; k < 24; k++) begin
         push(k % 8 == 0, k);
         if (k < 8) begin
            check("al_fill_sync", {15'b0, o_sync}, 16'h0);
         end else begin
            check("al_sync", {15'b0, o_sync}, {15'b0, ((k - 8) % 8) == 0});
            check("al_out", o_out, mk(((k - 8) / 8) * 8 + e1[(k - 8) % 8]));
         end
         check("al_err", {15'b0, o_err}, 16'h0);
      end

      // Pre-sync garbage is dropped.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         push(1'b0, 200 + k);
         check("gb_pre_sync", {15'b0, o_sync}, 16'h0);
      end
      for (int k = 0; k < 16; k++) begin
         push(k % 8 == 0, k);
         if (k < 8) begin
            check("gb_fill_sync", {15'b0, o_sync}, 16'h0);
         end else begin
            check("gb_sync", {15'b0, o_sync}, {15'b0, k == 8});
            check("gb_out", o_out, mk(e1[k - 8]));
         end
      end

      // Misplaced sync restarts the frame and pulses o_err.
      do_reset();
      push(1'b1, 0);
      push(1'b0, 1);
      push(1'b0, 2);
      check("ms_err_pre", {15'b0, o_err}, 16'h0);
      push(1'b1, 3);
      check("ms_err", {15'b0, o_err}, 16'h1);
      check("ms_sync", {15'b0, o_sync}, 16'h0);
      idle();
      check("ms_err_clr", {15'b0, o_err}, 16'h0);
      for (int k = 4; k < 11; k++) begin
         push(1'b0, k);
         check("ms_fill_sync", {15'b0, o_sync}, 16'h0);
         check("ms_fill_err", {15'b0, o_err}, 16'h0);
      end
      for (int k = 11; k < 19; k++) begin
         push(k == 11, k);
         check("ms_sync_run", {15'b0, o_sync}, {15'b0, k == 11});
         check("ms_out", o_out, mk(e3[k - 11]));
      end

      // One-in-three i_ce duty cycle; outputs hold between strobes.
      do_reset();
      for (int k = 0; k < 24; k++) begin
         push(k % 8 == 0, k);
         for (int r = 0; r < 3; r++) begin
            if (k < 8) begin
               check("dc_fill_sync", {15'b0, o_sync}, 16'h0);
            end else begin
               check("dc_sync", {15'b0, o_sync}, {15'b0, ((k - 8) % 8) == 0});
               check("dc_out", o_out, mk(((k - 8) / 8) * 8 + e1[(k - 8) % 8]));
            end
            check("dc_err", {15'b0, o_err}, 16'h0);
            if (r < 2) idle();
         end
      end

      // Reset mid-RUN at cnt=5, then realign on the next i_sync.
      do_reset();
      for (int k = 0; k < 13; k++) push(k % 8 == 0, k);
      check("mr_pre_out", o_out, mk(e1[4]));
      do_reset();
      check("mr_sync", {15'b0, o_sync}, 16'h0);
      check("mr_err", {15'b0, o_err}, 16'h0);
      check("mr_out", o_out, 16'h0);
      for (int k = 0; k < 3; k++) begin
         push(1'b0, 50 + k);
         check("mr_wait_sync", {15'b0, o_sync}, 16'h0);
      end
      for (int k = 0; k < 16; k++) begin
         push(k % 8 == 0, 60 + k);
         if (k < 8) begin
            check("mr_fill_sync", {15'b0, o_sync}, 16'h0);
         end else begin
            check("mr_run_sync", {15'b0, o_sync}, {15'b0, k == 8});
            check("mr_run_out", o_out, mk(60 + e1[k - 8]));
         end
      end

      // Free-run: sync only on the very first frame.
      do_reset();
      for (int k = 0; k < 32; k++) begin
         push(k == 0, k);
         if (k >= 8) begin
            check("fr_sync", {15'b0, o_sync}, {15'b0, (k % 8) == 0});
            check("fr_out", o_out, mk((k / 8 - 1) * 8 + brev3(k % 8)));
         end
         check("fr_err", {15'b0, o_err}, 16'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_bitreverse_in

// File: doc/bitreverse_in.md
Name: bitreverse_in

Overview:
- Input-side reorder for the DIT/IFFT path: the producer end of the frame-sync convention that `bitreverse` emits.
- Consumes a natural-order complex stream whose first sample of each frame is marked by i_sync, and emits the same frames in bit-reversed order with o_sync on each frame's first output sample.
- Ping-pong buffered, so input is sustained at one sample per i_ce.
- Adds frame alignment: waits for the first i_sync, re-aligns on a misplaced i_sync, and flags the misplacement on o_err.

Parameters:
- LGSIZE, 5, log2 of frame length N; must be ≥ 2.
- WIDTH, 24, bits per real/imag component; a sample is 2*WIDTH bits.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_ce  in  1  sample strobe; all state advances only when high (except o_err clear and reset)
- i_sync  in  1  high with i_ce on the first natural-order sample of a frame
- i_in  in  2*WIDTH  complex sample {real, imag}
- o_out  out  2*WIDTH  reordered sample, updated on i_ce
- o_sync  out  1  high with o_out holding output position 0 of a frame
- o_err  out  1  one-clock pulse: i_sync arrived mid-frame

Behaviour:
- Reset is on i_clk, synchronous, active-high. On reset: state=WAIT_SYNC, cnt=0, bank=0, o_out=0, o_sync=0, o_err=0. Memory contents are not reset.
- Storage: mem[0 .. 2N-1] of 2*WIDTH bits.
- Write address = {bank, bitrev(cnt[LGSIZE-1:0])}.
- Read address = {!bank, cnt}.
- A read and a write in the same cycle always hit opposite banks, so there is no collision.
- States:
  - WAIT_SYNC: i_ce && !i_sync → sample dropped, no write. i_ce && i_sync → write at {bank,0}, cnt←1, go to FILL.
  - FILL (first frame after alignment): each i_ce writes and increments cnt. o_out updates with junk; o_sync is held 0. On the write with cnt==N-1: cnt←0, bank←!bank, go to RUN.
  - RUN: each i_ce writes, and o_out ← mem[{!bank,cnt}]. o_sync ← (cnt==0) on the same edge. When cnt wraps from N-1 to 0, bank toggles.
- Misaligned sync, in FILL or RUN (i_ce && i_sync && cnt≠0):
  - The partial frame is discarded.
  - The sample is written at {bank,0}, cnt←1, state←FILL; bank is unchanged.
  - o_sync←0; o_err←1 on that edge.
- i_sync with cnt==0 is normal. A missing i_sync at cnt==0 is tolerated: the block free-runs.
- o_err is 1 for exactly one clock after the offending edge and is cleared on the next clock regardless of i_ce.
- Latency: input frame f's output occupies the N i_ce cycles that write frame f+1. o_sync for frame f appears on the edge that accepts frame f+1 sample 0.
- Ordering: output position j = input sample bitrev(j).
- o_out and o_sync hold their values while i_ce is low.
- Reset mid-frame: all buffered data is abandoned, and no o_sync is produced until a full frame has been collected after the next i_sync.

Decomposition:
- No shared package needed.
- The bit-reversal function is a generate loop local to the block.
- One natural sub-module: `brev_dpram`, a 2N×2*WIDTH simple dual-port RAM with a registered, i_ce-gated read, so it maps to block RAM.

Test Plan (LGSIZE=3, N=8, WIDTH=8):
- Aligned stream, i_ce=1 every clock, samples 0..23, i_sync on 0, 8, 16:
  - o_sync is first high on the edge after sample 8 is accepted.
  - o_out then reads 0,4,2,6,1,5,3,7, then 8,12,10,14,9,13,11,15.
- Pre-sync garbage: 5 samples with i_sync=0, then an aligned frame → the garbage never appears at o_out, and o_sync timing matches the aligned-stream case.
- Misaligned sync: i_sync on 0 and again on 3 (mid-frame) → o_err is high for exactly one clock after sample 3. The frame restarting at 3 outputs 3,7,5,9,4,8,6,10, and no o_sync occurs for the discarded frame.
- i_ce duty cycle 1-of-3, same data as the aligned-stream case:
  - Identical output sequence.
  - o_out and o_sync change only on i_ce edges.
  - o_err stays 0.
- Reset asserted during RUN at cnt=5 → o_sync and o_err are 0 immediately, and the state waits for the next i_sync.
- Free-run: i_sync only on the first frame, 4 frames pushed → o_sync is high every 8th i_ce and output order stays bit-reversed.
